// File: rtl/gray_monitor.sv
// Gray-code input monitor: synchronizes an asynchronous 4-bit Gray count, decodes it to binary,
// reports legal steps and their direction, counts illegal jumps and latches a fault after a run of them.
module gray_monitor #(
    parameter int ERR_W       = 8,
    parameter int FAULT_LIMIT = 3
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [3:0]       GrayIn,
    input  logic             ErrClr,
    output logic [3:0]       Bin,
    output logic             Valid,
    output logic             Dir,
    output logic             Err,
    output logic [ERR_W-1:0] ErrCount,
    output logic             Fault,
    output logic [1:0]       State
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'b00,
        ST_TRACK = 2'b01,
        ST_FAULT = 2'b10
    } state_e;

    localparam int CW = $clog2(FAULT_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(FAULT_LIMIT);

    function automatic logic [3:0] gray2bin(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        for (int i = 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [3:0]       sync1_q, s_q;
    logic [3:0]       p_q, p_d;
    logic [3:0]       bin_q, bin_d;
    logic             dir_q, dir_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [CW-1:0]    consec_q, consec_d;
    logic             fault_q, fault_d;
    logic             init_cnt_q, init_cnt_d;
    state_e           state_q, state_d;

    logic [3:0]       s_bin, p_bin_inc, diff;
    logic [ERR_W-1:0] err_cnt_inc;
    logic [CW-1:0]    consec_inc;

    assign s_bin       = gray2bin(s_q);
    assign p_bin_inc   = gray2bin(p_q) + 4'd1;
    assign diff        = s_q ^ p_q;
    assign err_cnt_inc = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + 1'b1;
    assign consec_inc  = consec_q + 1'b1;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        p_d        = p_q;
        bin_d      = bin_q;
        dir_d      = dir_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        err_cnt_d  = err_cnt_q;
        consec_d   = consec_q;
        init_cnt_d = init_cnt_q;
        state_d    = state_q;

        case (state_q)
            ST_INIT: begin
                // Two cycles while the synchronizer fills, then adopt its sample as the baseline.
                if (init_cnt_q) begin
                    p_d        = s_q;
                    bin_d      = s_bin;
                    init_cnt_d = 1'b0;
                    state_d    = ST_TRACK;
                end else begin
                    init_cnt_d = 1'b1;
                end
            end
            ST_TRACK: begin
                if (|diff) begin
                    p_d   = s_q;
                    bin_d = s_bin;
                    if ($onehot(diff)) begin
                        valid_d  = 1'b1;
                        dir_d    = (s_bin == p_bin_inc);
                        consec_d = '0;
                    end else begin
                        err_d     = 1'b1;
                        err_cnt_d = err_cnt_inc;
                        consec_d  = consec_inc;
                        if (consec_inc == LIMIT && !ErrClr) begin
                            state_d = ST_FAULT;
                        end
                    end
                end
            end
            ST_FAULT: begin
                p_d   = s_q;
                bin_d = s_bin;
                if (ErrClr) begin
                    init_cnt_d = 1'b0;
                    state_d    = ST_INIT;
                end
            end
            default: begin
                init_cnt_d = 1'b0;
                state_d    = ST_INIT;
            end
        endcase

        // The clear wins over any increment made above in the same cycle.
        if (ErrClr) begin
            err_cnt_d = '0;
            consec_d  = '0;
        end

        fault_d = (state_d == ST_FAULT);
    end

    always_ff @(posedge Clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values, keeping the synchronizer two stages deep.
        if (Rst) begin
            sync1_q    <= '0;
            s_q        <= '0;
            p_q        <= '0;
            bin_q      <= '0;
            dir_q      <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
            consec_q   <= '0;
            fault_q    <= 1'b0;
            init_cnt_q <= 1'b0;
            state_q    <= ST_INIT;
        end else begin
            sync1_q    <= GrayIn;
            s_q        <= sync1_q;
            p_q        <= p_d;
            bin_q      <= bin_d;
            dir_q      <= dir_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
            consec_q   <= consec_d;
            fault_q    <= fault_d;
            init_cnt_q <= init_cnt_d;
            state_q    <= state_d;
        end
    end

    assign Bin      = bin_q;
    assign Valid    = valid_q;
    assign Dir      = dir_q;
    assign Err      = err_q;
    assign ErrCount = err_cnt_q;
    assign Fault    = fault_q;
    assign State    = state_q;

endmodule
